// File: rtl/fft_axil_cfg_slave.sv
// AXI4-Lite configuration slave for the FFT accelerator: descriptor/config registers,
// start and soft-reset pulses toward the datapath, and the level interrupt.
//
// state  | meaning
// W_IDLE | waiting for address and data together, no response outstanding
// W_DATA | awready/wready high; commit on the edge both valids are seen
// W_RESP | bvalid held until bready
// R_IDLE | waiting for arvalid
// R_ADDR | arready high; read data is registered on the next edge
// R_DATA | rvalid held until rready
module fft_axil_cfg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGISTER       = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  input  logic                            core_busy,
  input  logic                            core_done,
  output logic [31:0]                     cfg_src_addr,
  output logic [31:0]                     cfg_src_len,
  output logic [31:0]                     cfg_dst_addr,
  output logic [31:0]                     cfg_dst_len,
  output logic [30:0]                     cfg_mode,
  output logic                            start_pulse,
  output logic                            soft_rst_pulse,
  output logic                            interrupt_out
);

  localparam logic [2:0] IDX_CTRL = 3'd0;
  localparam logic [2:0] IDX_SRC  = 3'd1;
  localparam logic [2:0] IDX_DST  = 3'd2;
  localparam logic [2:0] IDX_CFG  = 3'd3;
  localparam logic [2:0] IDX_IRQ  = 3'd4;
  localparam logic [2:0] LAST_IDX = 3'(NUM_REGISTER - 1);
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic [2:0]  waddr_q, waddr_d;
  logic [2:0]  raddr_q, raddr_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] src_q, src_d;
  logic [63:0] dst_q, dst_d;
  logic [30:0] cfg_q, cfg_d;
  logic        start_q, start_d;
  logic        srst_q, srst_d;
  logic        irq_q, irq_d;

  logic        commit;
  logic        widx_ok;
  logic        ctrl_wr;
  logic [63:0] cfg_merged_unused;
  logic        unused_bits;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign widx_ok = (waddr_q <= LAST_IDX);
  assign ctrl_wr = (waddr_q == IDX_CTRL) && s_axil_wstrb[0];
  assign cfg_merged_unused = merge_bytes({33'b0, cfg_q}, s_axil_wdata, s_axil_wstrb);
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[C_S_AXI_ADDR_WIDTH-1:6], s_axil_awaddr[2:0],
                         s_axil_araddr[C_S_AXI_ADDR_WIDTH-1:6], s_axil_araddr[2:0]};

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    bresp_d   = bresp_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cfg_d     = cfg_q;
    irq_d     = irq_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axil_awvalid && s_axil_wvalid) begin
          waddr_d   = s_axil_awaddr[5:3];
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axil_awvalid && s_axil_wvalid) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
          bresp_d   = (!widx_ok || (ctrl_wr && s_axil_wdata[1] && core_busy)) ? SLVERR : OKAY;
        end
      end
      W_RESP: begin
        if (s_axil_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    if (commit && widx_ok) begin
      case (waddr_q)
        IDX_SRC: src_d = merge_bytes(src_q, s_axil_wdata, s_axil_wstrb);
        IDX_DST: dst_d = merge_bytes(dst_q, s_axil_wdata, s_axil_wstrb);
        IDX_CFG: cfg_d = cfg_merged_unused[30:0];
        default: ;
      endcase
    end

    // Soft reset beats start when both bits arrive in one write.
    srst_d  = commit && widx_ok && ctrl_wr && s_axil_wdata[0];
    start_d = commit && widx_ok && ctrl_wr && s_axil_wdata[1] && !s_axil_wdata[0] && !core_busy;

    // A done pulse on the clearing edge must not be lost, so set has priority.
    if (core_done) begin
      irq_d = 1'b1;
    end else if (commit && widx_ok &&
                 (((waddr_q == IDX_IRQ) && s_axil_wstrb[0]) || (ctrl_wr && s_axil_wdata[0]))) begin
      irq_d = 1'b0;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axil_arvalid) begin
          raddr_d   = s_axil_araddr[5:3];
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        r_state_d = R_DATA;
        rdata_d   = '0;
        rresp_d   = OKAY;
        if (raddr_q > LAST_IDX) begin
          rresp_d = SLVERR;
        end else begin
          case (raddr_q)
            IDX_CTRL: rdata_d = {62'b0, core_busy, 1'b0};
            IDX_SRC:  rdata_d = src_q;
            IDX_DST:  rdata_d = dst_q;
            IDX_CFG:  rdata_d = {33'b0, cfg_q};
            IDX_IRQ:  rdata_d = {63'b0, irq_q};
            default:  rresp_d = SLVERR;
          endcase
        end
      end
      R_DATA: begin
        if (s_axil_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      waddr_q   <= '0;
      raddr_q   <= '0;
      bresp_q   <= OKAY;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      cfg_q     <= '0;
      start_q   <= 1'b0;
      srst_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cfg_q     <= cfg_d;
      start_q   <= start_d;
      srst_q    <= srst_d;
      irq_q     <= irq_d;
    end
  end

  assign s_axil_awready = (w_state_q == W_DATA);
  assign s_axil_wready  = (w_state_q == W_DATA);
  assign s_axil_bvalid  = (w_state_q == W_RESP);
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = (r_state_q == R_ADDR);
  assign s_axil_rvalid  = (r_state_q == R_DATA);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign cfg_src_addr   = src_q[63:32];
  assign cfg_src_len    = src_q[31:0];
  assign cfg_dst_addr   = dst_q[63:32];
  assign cfg_dst_len    = dst_q[31:0];
  assign cfg_mode       = cfg_q;
  assign start_pulse    = start_q;
  assign soft_rst_pulse = srst_q;
  assign interrupt_out  = irq_q;

endmodule

// File: doc/fft_axil_cfg_slave.md
Name: fft_axil_cfg_slave

Overview:
- AXI4-Lite responder that terminates the host configuration bus of the FFT accelerator.
- Holds the source and destination DMA descriptors, the transform configuration and the control register.
- Issues single-cycle start and soft-reset pulses to the FFT datapath.
- Owns the level-sensitive interrupt_out, which is set when the core reports done and cleared by a host write.

Parameters:
- C_S_AXI_DATA_WIDTH, 64, AXI-Lite data width; the register map assumes 64.
- C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width.
- NUM_REGISTER, 5, number of decoded 64-bit registers, indexed by addr[5:3].

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axil_awaddr  in  32  write address.
- s_axil_awprot  in  3  write protection; ignored.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  64  write data.
- s_axil_wstrb  in  8  write byte enables.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  32  read address.
- s_axil_arprot  in  3  read protection; ignored.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  64  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.
- core_busy  in  1  FFT core is running.
- core_done  in  1  single-cycle completion pulse from the core.
- cfg_src_addr  out  32  reg1[63:32].
- cfg_src_len  out  32  reg1[31:0].
- cfg_dst_addr  out  32  reg2[63:32].
- cfg_dst_len  out  32  reg2[31:0].
- cfg_mode  out  31  reg3[30:0]; bit0 = inverse, [4:1] = log2 N, [30:5] = options.
- start_pulse  out  1  one-cycle start.
- soft_rst_pulse  out  1  one-cycle datapath soft reset.
- interrupt_out  out  1  level interrupt.

Behaviour:
- Reset: every output is 0, and registers 1–3 are 0.
- Register map, idx = addr[5:3]:
  - idx 0, CTRL: write bit0 = soft reset, bit1 = start; reads as {62'b0, core_busy, 1'b0}.
  - idx 1, SRC: descriptor, read/write.
  - idx 2, DST: descriptor, read/write.
  - idx 3, CFG: read/write; bits [63:31] read 0.
  - idx 4, IRQ: any write clears the interrupt; reads as {63'b0, interrupt_out}.
  - idx 5..7: decode error.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: when awvalid && wvalid && !bvalid, latch awaddr at that edge, assert awready and wready for exactly one cycle, go to W_DATA.
  - W_DATA: the commit edge is the one where awvalid && awready && wvalid && wready. Use the latched address and the wdata sampled at this edge, not the wdata present at the address edge. Drop both readies, set bvalid, go to W_RESP.
  - W_RESP: hold bvalid and bresp until bready; return to W_IDLE on the edge after bvalid && bready.
  - No new write is accepted while bvalid = 1, even if awvalid and wvalid are still asserted.
  - Write latency from address acceptance: 1 cycle to commit, bvalid 1 cycle after commit.
- wstrb: applied per byte on registers 1–3. CTRL and IRQ act on any write with wstrb[0] = 1.
- bresp:
  - OKAY (2'b00) normally.
  - SLVERR (2'b10) for idx 5..7; the write is discarded.
  - SLVERR for a start write while core_busy = 1; start_pulse is suppressed, other CTRL bits still act.
- start_pulse and soft_rst_pulse: high for the single cycle after the commit edge.
  - If both bits are written together, soft reset wins and start is dropped.
- Descriptor writes while core_busy = 1 update the registers. The core must sample the descriptors only at start_pulse.
- Interrupt:
  - interrupt_out is set on the cycle after core_done.
  - It is cleared on the cycle after an IRQ commit.
  - If core_done and the IRQ commit occur on the same edge, set wins and interrupt_out stays 1.
  - soft_rst_pulse also clears interrupt_out.
- Read FSM:
  - When arvalid && !rvalid && !arready, assert arready for one cycle and latch araddr.
  - On the next edge, rvalid = 1 with rdata and rresp registered.
  - Hold rdata and rresp stable until rready; rvalid falls on the edge where rvalid && rready.
  - Read latency: arvalid to rvalid is 2 cycles.
  - idx 5..7 return rdata = 0 and rresp = SLVERR.
- The read and write channels are independent and may be active on the same cycle. A read of a register being committed on the same edge returns the old value.
- rst_n asserted mid-transaction:
  - All FSMs return to idle, valid and ready outputs clear immediately, and pending responses are lost.
  - Register contents are reset.

Test Plan:
1. Write idx1 = {32'h8, 32'd64}, then read idx1 → bresp 00, awready is a 1-cycle pulse, and the read returns 64'h0000_0008_0000_0040 with rresp 00. Change awaddr to 0 one cycle after awvalid → the write still lands in idx1.
2. Write idx3 with wstrb 8'h01, data 64'hFFFF_FFFF_FFFF_FF07 → cfg_mode = 31'h7, and upper bytes are unchanged.
3. Write idx0 = 2 with core_busy = 0 → start_pulse is high exactly 1 cycle and bresp = 00. Repeat with core_busy = 1 → no pulse and bresp = 10.
4. Pulse core_done → interrupt_out = 1 the next cycle. Write idx4 = 0 → interrupt_out = 0 one cycle after commit. Align core_done with the idx4 commit → interrupt_out stays 1.
5. Read idx6 → rdata = 0, rresp = 10. Hold rready low 5 cycles → rvalid and rdata stay stable.
6. Drop rst_n while bvalid is pending → bvalid = 0 immediately, idx1 reads 0 after release, and interrupt_out = 0.
